// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: generates the PC, issues one handshaked imem request at a time,
// and presents whole instructions to IF/ID. It also handles stall and flush/redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        kill_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_out_reg;
    logic        valid_reg;

    // Request side depends only on registered state, never on imem_ready_i.
    assign imem_req_o  = (state_reg == REQ);
    assign imem_addr_o = pc_reg;
    assign instr_o     = instr_reg;
    assign pc_o        = pc_out_reg;
    assign valid_o     = valid_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            kill_reg   <= 1'b0;
            instr_reg  <= 32'h0;
            pc_out_reg <= 32'h0;
            valid_reg  <= 1'b0;
        end else if (flush_i) begin
            pc_reg     <= target_i;
            instr_reg  <= 32'h0;
            pc_out_reg <= 32'h0;
            valid_reg  <= 1'b0;
            case (state_reg)
                IDLE: state_reg <= IDLE;
                REQ: begin
                    // An accepted old-address request still returns data; mark it for discard.
                    if (imem_ready_i) begin
                        kill_reg  <= 1'b1;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        kill_reg  <= 1'b0;
                        state_reg <= REQ;
                    end else begin
                        kill_reg  <= 1'b1;
                    end
                end
                HOLD: state_reg <= REQ;
                default: state_reg <= IDLE;
            endcase
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i)
                        state_reg <= REQ;
                end
                REQ: begin
                    if (imem_ready_i)
                        state_reg <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill_reg) begin
                            kill_reg  <= 1'b0;
                            state_reg <= REQ;
                        end else begin
                            instr_reg  <= imem_rdata_i;
                            pc_out_reg <= pc_reg;
                            valid_reg  <= 1'b1;
                            pc_reg     <= pc_reg + 32'd4;
                            state_reg  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        instr_reg  <= 32'h0;
                        pc_out_reg <= 32'h0;
                        valid_reg  <= 1'b0;
                        state_reg  <= REQ;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed fetch/stall/flush/reset sequences,
// with presented instructions compared against a scoreboard of expected {pc, instr}.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic        flush;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic        prev_valid = 1'b0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stall_i      (stall),
        .flush_i      (flush),
        .target_i     (target),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ready_i (imem_ready),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .instr_o      (instr),
        .pc_o         (pc),
        .valid_o      (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0100)
            return 32'h0050_0093;
        return (addr * 32'd3) ^ 32'h1357_9bdf;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each new presented instruction must match the oldest expected one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr_pc", pc, 32'hxxxx_xxxx);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    $display("fetched pc=%h instr=%h (expected pc=%h instr=%h)",
                             pc, instr, e[63:32], e[31:0]);
                    check("sb_pc", pc, e[63:32]);
                    check("sb_instr", instr, e[31:0]);
                end
            end
            if (!valid) begin
                check("idle_instr_zero", instr, 32'h0);
                check("idle_pc_zero", pc, 32'h0);
            end
            prev_valid = valid;
        end
    end

    // Starting in REQ: wait ready_delay cycles, accept, return data; ends in HOLD.
    task automatic fetch_one(input logic [31:0] addr, input int ready_delay);
        for (int i = 0; i < ready_delay; i++) begin
            imem_ready = 1'b0;
            check("bp_req", {31'b0, imem_req}, 32'd1);
            check("bp_addr", imem_addr, addr);
            tick();
        end
        imem_ready = 1'b1;
        check("req_valid", {31'b0, imem_req}, 32'd1);
        check("req_addr", imem_addr, addr);
        tick();
        imem_ready = 1'b0;
        check("wait_no_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(addr);
        exp_q.push_back({addr, mem_word(addr)});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check("latency_valid", {31'b0, valid}, 32'd1);
    endtask

    task automatic release_to(input logic [31:0] next_addr);
        stall = 1'b0;
        tick();
        check("release_valid", {31'b0, valid}, 32'd0);
        check("release_req", {31'b0, imem_req}, 32'd1);
        check("release_addr", imem_addr, next_addr);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; target = 32'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        tick();
        tick();
        mon_en = 1'b1;
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0100);
        rst = 1'b0;
        tick();
        check("idle_no_req", {31'b0, imem_req}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;

        // Reset/start then stall for 4 cycles
        fetch_one(32'h0000_0100, 0);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_req", {31'b0, imem_req}, 32'd0);
            check("stall_pc", pc, 32'h0000_0100);
            check("stall_instr", instr, 32'h0050_0093);
        end
        release_to(32'h0000_0104);

        // Backpressure
        fetch_one(32'h0000_0104, 3);
        release_to(32'h0000_0108);

        // Flush while outstanding
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        flush = 1'b1; target = 32'h0000_0200;
        tick();
        flush = 1'b0;
        check("fo_valid", {31'b0, valid}, 32'd0);
        check("fo_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0000_0108);
        tick();
        imem_rvalid = 1'b0;
        check("fo_drop_valid", {31'b0, valid}, 32'd0);
        check("fo_addr", imem_addr, 32'h0000_0200);
        fetch_one(32'h0000_0200, 0);
        release_to(32'h0000_0204);

        // Flush coincident with rvalid
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0000_0204);
        flush = 1'b1; target = 32'h0000_0300;
        tick();
        imem_rvalid = 1'b0; flush = 1'b0;
        check("fr_valid", {31'b0, valid}, 32'd0);
        check("fr_req", {31'b0, imem_req}, 32'd1);
        check("fr_addr", imem_addr, 32'h0000_0300);
        fetch_one(32'h0000_0300, 0);
        release_to(32'h0000_0304);

        // Flush in REQ with ready=1
        imem_ready = 1'b1; flush = 1'b1; target = 32'h0000_0400;
        tick();
        imem_ready = 1'b0; flush = 1'b0;
        check("fq_req", {31'b0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0000_0304);
        tick();
        imem_rvalid = 1'b0;
        check("fq_drop_valid", {31'b0, valid}, 32'd0);
        check("fq_addr", imem_addr, 32'h0000_0400);
        fetch_one(32'h0000_0400, 0);

        // Flush with stall in HOLD, target at the top of the address space
        stall = 1'b1; flush = 1'b1; target = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0; stall = 1'b0;
        check("fs_valid", {31'b0, valid}, 32'd0);
        check("fs_req", {31'b0, imem_req}, 32'd1);
        check("fs_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 0);
        release_to(32'h0000_0000);

        // Flush in REQ with ready=0 redirects the pending address
        flush = 1'b1; target = 32'h0000_0500;
        tick();
        flush = 1'b0;
        check("fn_req", {31'b0, imem_req}, 32'd1);
        check("fn_addr", imem_addr, 32'h0000_0500);

        // Reset in WAIT with a late rvalid
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        tick();
        check("rw_valid", {31'b0, valid}, 32'd0);
        check("rw_instr", instr, 32'h0);
        check("rw_pc", pc, 32'h0);
        check("rw_req", {31'b0, imem_req}, 32'd0);
        check("rw_addr", imem_addr, 32'h0000_0100);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit that generates the program counter, requests instructions from a handshaked instruction memory and drives the fetch-side inputs of the IF/ID pipeline register: `instr_o`, `pc_o` and `valid_o`. It accepts the hazard unit's stall and the branch unit's flush/redirect, so the IF/ID register only ever sees whole, correctly ordered instructions. It sits between the instruction memory port and the IF/ID register. It supports one outstanding memory request.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: run enable; gates leaving IDLE only.
- `stall_i` in 1: IF/ID is holding; the presented instruction is not consumed this cycle.
- `flush_i` in 1: redirect request; discards the in-flight or presented instruction.
- `target_i` in 32: redirect PC, sampled when `flush_i`=1.
- `imem_req_o` out 1: request valid; equals (state==REQ).
- `imem_addr_o` out 32: request address; equals `pc_q`.
- `imem_ready_i` in 1: memory accepts the request this cycle.
- `imem_rvalid_i` in 1: read data valid (one cycle pulse).
- `imem_rdata_i` in 32: instruction word.
- `instr_o` out 32: fetched instruction; 32'b0 whenever `valid_o`=0.
- `pc_o` out 32: PC of `instr_o`; 32'b0 whenever `valid_o`=0.
- `valid_o` out 1: `instr_o`/`pc_o` hold a live instruction.

## Operation
- State: `state` ∈ {IDLE, REQ, WAIT, HOLD}, `pc_q` (32), `kill` (1), plus output registers.
- Reset (priority over everything): state=IDLE, `pc_q`=RESET_PC, `kill`=0, `valid_o`=0, `instr_o`=0, `pc_o`=0. `imem_req_o`=0 follows from state.
- IDLE: `start_i`=1 -> REQ. Otherwise stay.
- REQ: `imem_req_o`=1. `imem_ready_i`=1 -> WAIT (request issued). Otherwise stay, with address held stable.
- WAIT, `imem_rvalid_i`=1 and `kill`=0:
  - `instr_o`<=`imem_rdata_i`, `pc_o`<=`pc_q`, `valid_o`<=1.
  - `pc_q`<=`pc_q`+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
  - -> HOLD.
- WAIT, `imem_rvalid_i`=1 and `kill`=1: drop the data, `kill`<=0, -> REQ.
- `imem_rvalid_i` outside WAIT is ignored.
- HOLD, `stall_i`=0: instruction consumed this cycle. `valid_o`<=0, `instr_o`/`pc_o`<=0, -> REQ.
- HOLD, `stall_i`=1: hold all outputs unchanged.
- `start_i` falling mid-operation has no effect. The fetch stream continues until reset.
- Flush (priority over stall and normal transitions). Always: `pc_q`<=`target_i`, `valid_o`<=0, `instr_o`<=0, `pc_o`<=0. Then by state:
  - IDLE: stay IDLE.
  - REQ, `imem_ready_i`=0: stay REQ. The address changes to the target next cycle; this is the only permitted address change while a request is pending.
  - REQ, `imem_ready_i`=1: the old-address request is issued. `kill`<=1, -> WAIT.
  - WAIT, `imem_rvalid_i`=0: `kill`<=1, stay WAIT.
  - WAIT, `imem_rvalid_i`=1: drop the data, `kill`<=0, -> REQ.
  - HOLD: -> REQ.
- Invariants:
  - At most one request is outstanding.
  - A killed response never reaches `instr_o`.
  - Instructions are presented in PC order.

## Timing
- Minimum fetch latency, with ready immediate and rvalid one cycle after acceptance:
  - cycle 0: REQ accepted;
  - cycle 1: WAIT, rvalid;
  - cycle 2: `valid_o`=1.
- Throughput is one instruction per 3 cycles when unstalled with a single-cycle memory.
- Outputs are fully registered. `imem_req_o`/`imem_addr_o` derive from registered state only; there is no combinational path from `imem_ready_i`.
- Flush takes effect on outputs the cycle after `flush_i`=1. The first request to the target issues in the following REQ cycle.
- Reset asserted mid-fetch: next cycle is in the reset state, and a late `imem_rvalid_i` is ignored (state IDLE).

## Test plan
- **Reset/start.** Reset with RESET_PC=0x100, then `start_i`=1, ready=1, rvalid one cycle later with rdata 0x00500093. Required: `imem_addr_o`=0x100, then `valid_o`=1, `instr_o`=0x00500093, `pc_o`=0x100; next request address 0x104.
- **Stall.** While in HOLD, `stall_i`=1 for 4 cycles. Required: `instr_o`/`pc_o` stable, `imem_req_o`=0. Release stall -> `valid_o`=0 next cycle, request to 0x104.
- **Backpressure.** `imem_ready_i`=0 for 3 cycles. Required: `imem_req_o`=1 and `imem_addr_o` constant throughout; single acceptance on the ready cycle.
- **Flush while outstanding.** `flush_i`=1, `target_i`=0x200 in WAIT before rvalid. Required: the returning data is dropped (`valid_o` stays 0), the next request is to 0x200, and the instruction presented has `pc_o`=0x200.
- **Flush boundaries.**
  - Flush coincident with rvalid: data dropped, request to target.
  - Flush in REQ with ready=1: `kill` set, old response dropped.
  - Flush with `stall_i`=1 in HOLD: flush wins, `valid_o`=0.
- **Wrap and reset.** `target_i`=0xFFFF_FFFC -> next PC 0x0. Reset asserted in WAIT -> IDLE and all outputs 0, with a late rvalid ignored.
